// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage IEEE-754 single add/sub (align | add+lzc | normalize/round/pack), 1 op/cycle.
// Latency 3 cycles; out_ready low stalls the output and full stages behind it, bubbles still fill.
module fadd_pipe #(
  parameter int TAG_W     = 5,
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic ld1, ld2, ld3;

  logic [26:0]      s1_sig_l_q, s1_sig_l_d, s1_sig_s_q, s1_sig_s_d;
  logic [7:0]       s1_exp_q, s1_exp_d;
  logic             s1_sign_q, s1_sign_d, s1_esub_q, s1_esub_d;
  logic             s1_inf_q, s1_inf_d, s1_zz_q, s1_zz_d, s1_zsign_q, s1_zsign_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic [27:0]      s2_sum_q, s2_sum_d;
  logic [4:0]       s2_lzc_q, s2_lzc_d;
  logic [7:0]       s2_exp_q, s2_exp_d;
  logic             s2_sign_q, s2_sign_d, s2_inf_q, s2_inf_d, s2_zz_q, s2_zz_d, s2_zsign_q, s2_zsign_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic [31:0]      y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic        sb, swap;
  logic [30:0] ma, mb, ml, ms;
  logic [7:0]  diff;
  logic [23:0] sig_s;
  logic [49:0] shx;
  logic [26:0] field_s;
  logic [27:0] sum;
  logic [4:0]  lzc;
  logic [27:0] norm;
  logic        rnd;
  logic [24:0] mant_r;
  logic signed [9:0] exp_r;
  logic [22:0] frac;

  // A stage loads when empty or when its contents move on; in_ready is stage 1's load.
  assign ld3       = !v3_q || out_ready;
  assign ld2       = !v2_q || ld3;
  assign ld1       = !v1_q || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign tag_out   = tag_q;

  always_comb begin
    v1_d = ld1 ? in_valid : v1_q;
    v2_d = ld2 ? v1_q : v2_q;
    v3_d = ld3 ? v2_q : v3_q;
  end

  // Stage 1: flush denormals, order by magnitude, align the smaller significand with sticky.
  always_comb begin
    sb      = x2[31] ^ sub;
    ma      = (x1[30:23] == 8'd0) ? 31'd0 : x1[30:0];
    mb      = (x2[30:23] == 8'd0) ? 31'd0 : x2[30:0];
    swap    = mb > ma;
    ml      = swap ? mb : ma;
    ms      = swap ? ma : mb;
    diff    = ml[30:23] - ms[30:23];
    sig_s   = (ms[30:23] == 8'd0) ? 24'd0 : {1'b1, ms[22:0]};
    shx     = {sig_s, 26'd0} >> diff;
    field_s = (diff >= 8'd27) ? {26'd0, |sig_s} : {shx[49:24], |shx[23:0]};

    s1_sig_l_d = s1_sig_l_q;
    s1_sig_s_d = s1_sig_s_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_esub_d  = s1_esub_q;
    s1_inf_d   = s1_inf_q;
    s1_zz_d    = s1_zz_q;
    s1_zsign_d = s1_zsign_q;
    s1_tag_d   = s1_tag_q;
    if (ld1) begin
      s1_sig_l_d = {(ml[30:23] != 8'd0), ml[22:0], 3'b000};
      s1_sig_s_d = field_s;
      s1_exp_d   = ml[30:23];
      s1_sign_d  = swap ? sb : x1[31];
      s1_esub_d  = x1[31] ^ sb;
      s1_inf_d   = (x1[30:23] == 8'hFF) || (x2[30:23] == 8'hFF);
      s1_zz_d    = (ma == 31'd0) && (mb == 31'd0);
      s1_zsign_d = x1[31] & sb;
      s1_tag_d   = tag_in;
    end
  end

  // Stage 2: magnitude add/subtract (large - small never goes negative) and leading-zero count.
  always_comb begin
    sum = s1_esub_q ? ({1'b0, s1_sig_l_q} - {1'b0, s1_sig_s_q})
                    : ({1'b0, s1_sig_l_q} + {1'b0, s1_sig_s_q});
    lzc = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (sum[i]) lzc = 5'(27 - i);
    end

    s2_sum_d   = s2_sum_q;
    s2_lzc_d   = s2_lzc_q;
    s2_exp_d   = s2_exp_q;
    s2_sign_d  = s2_sign_q;
    s2_inf_d   = s2_inf_q;
    s2_zz_d    = s2_zz_q;
    s2_zsign_d = s2_zsign_q;
    s2_tag_d   = s2_tag_q;
    if (ld2) begin
      s2_sum_d   = sum;
      s2_lzc_d   = lzc;
      s2_exp_d   = s1_exp_q;
      s2_sign_d  = s1_sign_q;
      s2_inf_d   = s1_inf_q;
      s2_zz_d    = s1_zz_q;
      s2_zsign_d = s1_zsign_q;
      s2_tag_d   = s1_tag_q;
    end
  end

  // Stage 3: the binary point sits at bit 27 so a carry-out (lzc=0) and a plain result share one path.
  always_comb begin
    norm   = s2_sum_q << s2_lzc_q;
    rnd    = ROUND_RNE & norm[3] & (norm[2] | norm[1] | norm[0] | norm[4]);
    mant_r = {1'b0, norm[27:4]} + {24'd0, rnd};
    exp_r  = $signed({2'b00, s2_exp_q}) + 10'sd1 - $signed({5'd0, s2_lzc_q})
           + $signed({9'd0, mant_r[24]});
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    y_d   = y_q;
    ovf_d = ovf_q;
    tag_d = tag_q;
    if (ld3 && v2_q) begin
      tag_d = s2_tag_q;
      ovf_d = 1'b0;
      if (s2_inf_q) begin
        y_d   = {s2_sign_q, 8'hFF, 23'd0};
        ovf_d = 1'b1;
      end else if (s2_zz_q) begin
        y_d = {s2_zsign_q, 31'd0};
      end else if (s2_sum_q == 28'd0) begin
        y_d = 32'd0;
      end else if (exp_r >= 10'sd255) begin
        y_d   = {s2_sign_q, 8'hFF, 23'd0};
        ovf_d = 1'b1;
      end else if (exp_r <= 10'sd0) begin
        y_d = 32'd0;
      end else begin
        y_d = {s2_sign_q, exp_r[7:0], frac};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      s1_sig_l_q <= '0;
      s1_sig_s_q <= '0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_esub_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zz_q    <= 1'b0;
      s1_zsign_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_sum_q   <= '0;
      s2_lzc_q   <= '0;
      s2_exp_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_zz_q    <= 1'b0;
      s2_zsign_q <= 1'b0;
      s2_tag_q   <= '0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      tag_q      <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      s1_sig_l_q <= s1_sig_l_d;
      s1_sig_s_q <= s1_sig_s_d;
      s1_exp_q   <= s1_exp_d;
      s1_sign_q  <= s1_sign_d;
      s1_esub_q  <= s1_esub_d;
      s1_inf_q   <= s1_inf_d;
      s1_zz_q    <= s1_zz_d;
      s1_zsign_q <= s1_zsign_d;
      s1_tag_q   <= s1_tag_d;
      s2_sum_q   <= s2_sum_d;
      s2_lzc_q   <= s2_lzc_d;
      s2_exp_q   <= s2_exp_d;
      s2_sign_q  <= s2_sign_d;
      s2_inf_q   <= s2_inf_d;
      s2_zz_q    <= s2_zz_d;
      s2_zsign_q <= s2_zsign_d;
      s2_tag_q   <= s2_tag_d;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
      tag_q      <= tag_d;
    end
  end
endmodule
